// File: rtl/fifo_drain.sv
// Burst drain engine: pulls a requested number of words from a FIFO with a one-cycle
// read latency and presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_error_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W:0]   len_q, len_d;
  logic [LEN_W:0]   issued_q, issued_d;
  logic [LEN_W:0]   sent_q, sent_d;
  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic       run;
  logic       xfer;
  logic       cap;
  logic       rd_en;
  logic [1:0] slots_used;
  logic [1:0] wr_idx;

  assign run  = (state_q == S_RUN);
  assign cap  = run && infl_q;
  assign xfer = m_valid_o && m_ready_i;

  // A word leaving this cycle frees its slot, so a new read may be issued in the
  // same cycle; this is what sustains one word per cycle with only two entries.
  assign slots_used = occ_q + {1'b0, infl_q} - {1'b0, xfer};
  assign rd_en      = rst_ni && run && !fifo_empty_i && (issued_q < len_q)
                      && (slots_used < 2'd2);

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = rst_ni && run && (occ_q != 2'd0);
  assign m_data_o     = m_valid_o ? buf0_q : '0;
  assign busy_o       = rst_ni && (state_q != S_IDLE);
  assign done_o       = rst_ni && (state_q == S_DONE);
  assign err_o        = rst_ni && err_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    infl_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d  = S_RUN;
          len_d    = {1'b0, len_i};
          issued_d = '0;
          sent_d   = '0;
          err_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (fifo_error_i) err_d = 1'b1;
        issued_d = issued_q + {{LEN_W{1'b0}}, rd_en};
        sent_d   = sent_q + {{LEN_W{1'b0}}, xfer};
        infl_d   = rd_en;
        if (sent_d == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift out the head first, then the returning read lands behind whatever remains.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    wr_idx = occ_q - {1'b0, xfer};
    if (xfer) buf0_d = buf1_q;
    if (cap) begin
      if (wr_idx == 2'd0) buf0_d = fifo_rdata_i;
      else                buf1_d = fifo_rdata_i;
    end
    occ_d = occ_q + {1'b0, cap} - {1'b0, xfer};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      occ_q    <= 2'd0;
      infl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboarded bench for fifo_drain: a behavioural FIFO supplies words, the expected
// stream is the FIFO push order, and a monitor pops and compares on every transfer.
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] len_i;
  logic       fifo_empty_i;
  logic       fifo_error_i;
  logic [7:0] fifo_rdata_i;
  logic       fifo_rd_en_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  fifo_drain #(.WIDTH(8), .LEN_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .len_i        (len_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_error_i (fifo_error_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial forever #5 clk = ~clk;

  // Behavioural FIFO storage and expected-output scoreboard
  logic [7:0] fifo_mem [256];
  int         wptr = 0;
  int         rptr = 0;
  logic       stall = 1'b0;
  logic [7:0] exp_q [$];
  assign fifo_empty_i = (rptr == wptr) || stall;

  int checks = 0;
  int errors = 0;

  // Monitor observations
  int cyc = 0, rd_total = 0, xfer_total = 0, done_total = 0;
  int start_cyc = 0, first_v_cyc = 0, first_x_cyc = 0, last_x_cyc = 0;
  bit got_v = 1'b0, got_x = 1'b0, err_at_done = 1'b0;
  int ready_mode = 0;
  int dropped_total = 0;

  function automatic void check_eq(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [7:0] d);
    fifo_mem[wptr[7:0]] = d;
    wptr++;
    exp_q.push_back(d);
  endtask

  task automatic start(int len);
    start_i = 1'b1;
    len_i   = 8'(len);
    tick(1);
    start_i = 1'b0;
    len_i   = 8'd0;
  endtask

  task automatic wait_done(int budget, output bit ok);
    int d0;
    d0 = done_total;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_total != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_burst(string tag, int len, int rd0, int x0, int d0);
    bit ok;
    wait_done(300, ok);
    check_eq({tag, "_done_seen"}, int'(ok), 1);
    tick(2);
    check_eq({tag, "_xfers"}, xfer_total - x0, len);
    check_eq({tag, "_reads"}, rd_total - rd0, len);
    check_eq({tag, "_done_pulses"}, done_total - d0, 1);
    check_eq({tag, "_idle_busy"}, int'(busy_o), 0);
  endtask

  task automatic run_burst(string tag, int len, int mode, bit poke);
    int rd0, x0, d0;
    rd0 = rd_total; x0 = xfer_total; d0 = done_total;
    ready_mode = mode;
    start(len);
    if (poke) start(3);
    finish_burst(tag, len, rd0, x0, d0);
  endtask

  task automatic fifo_model();
    forever begin
      @(posedge clk);
      if (fifo_rd_en_o) begin
        fifo_rdata_i <= fifo_mem[rptr[7:0]];
        rptr <= rptr + 1;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       begin m_ready_i = 1'b1; stall = 1'b0; end
        1:       begin m_ready_i = 1'b0; stall = 1'b0; end
        default: begin
          m_ready_i = ($urandom_range(0, 3) != 0);
          stall     = ($urandom_range(0, 4) == 0);
        end
      endcase
    end
  endtask

  task automatic monitor();
    bit         pv, pr;
    logic [7:0] pd, e;
    pv = 1'b0; pr = 1'b0; pd = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        check_eq("reset_outputs",
                 int'({fifo_rd_en_o, m_valid_o, busy_o, done_o, err_o}), 0);
        check_eq("reset_data", int'(m_data_o), 0);
        pv = 1'b0;
        continue;
      end
      if (start_i) begin
        start_cyc = cyc; got_v = 1'b0; got_x = 1'b0;
      end
      if (fifo_rd_en_o) begin
        rd_total++;
        check_eq("rd_while_empty", int'(fifo_empty_i), 0);
      end
      if (m_valid_o && !got_v) begin
        got_v = 1'b1; first_v_cyc = cyc;
      end
      if (pv && !pr) begin
        check_eq("hold_valid", int'(m_valid_o), 1);
        check_eq("hold_data", int'(m_data_o), int'(pd));
      end
      if (m_valid_o && m_ready_i) begin
        xfer_total++;
        if (!got_x) begin
          got_x = 1'b1; first_x_cyc = cyc;
        end
        last_x_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", int'(m_data_o), -1);
        end else begin
          e = exp_q.pop_front();
          check_eq("data", int'(m_data_o), int'(e));
        end
      end
      if (done_o) begin
        done_total++;
        err_at_done = err_o;
      end
      pv = m_valid_o; pr = m_ready_i; pd = m_data_o;
    end
  endtask

  initial begin
    int rd0, x0, d0, lost, len;
    bit ok;
    rst_ni = 1'b0; start_i = 1'b0; len_i = 8'd0; fifo_error_i = 1'b0;
    m_ready_i = 1'b1; fifo_rdata_i = 8'd0;
    fork
      fifo_model();
      ready_driver();
      monitor();
    join_none
    tick(3);
    rst_ni = 1'b1;
    tick(1);
    check_eq("post_reset_busy", int'(busy_o), 0);
    check_eq("post_reset_valid", int'(m_valid_o), 0);

    // Preloaded back-to-back burst
    for (int i = 1; i <= 4; i++) push(8'(i));
    run_burst("basic", 4, 0, 1'b0);
    check_eq("basic_streaming", last_x_cyc - first_x_cyc, 3);
    check_eq("basic_first_valid_latency", int'(first_v_cyc - start_cyc >= 3), 1);

    // Downstream backpressure right after the first valid word
    for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
    rd0 = rd_total; x0 = xfer_total; d0 = done_total;
    ready_mode = 1;
    start(3);
    for (int i = 0; i < 50 && !got_v; i++) tick(1);
    check_eq("bp_valid_seen", int'(got_v), 1);
    tick(5);
    check_eq("bp_reads_bounded", int'(rd_total - rd0 <= 2), 1);
    check_eq("bp_head_word", int'(m_data_o), 8'hA0);
    ready_mode = 0;
    finish_burst("bp", 3, rd0, x0, d0);

    // Burst begins on an empty FIFO and waits for data
    rd0 = rd_total; x0 = xfer_total; d0 = done_total;
    ready_mode = 0;
    start(2);
    tick(4);
    check_eq("empty_no_reads", rd_total - rd0, 0);
    check_eq("empty_busy", int'(busy_o), 1);
    push(8'h5A);
    push(8'hA5);
    finish_burst("empty", 2, rd0, x0, d0);

    // Error pulse mid-burst is sticky until the next accepted start
    for (int i = 0; i < 4; i++) push(8'($urandom));
    rd0 = rd_total; x0 = xfer_total; d0 = done_total;
    ready_mode = 2;
    start(4);
    tick(2);
    fifo_error_i = 1'b1;
    tick(1);
    fifo_error_i = 1'b0;
    finish_burst("err", 4, rd0, x0, d0);
    check_eq("err_at_done", int'(err_at_done), 1);
    check_eq("err_held_idle", int'(err_o), 1);
    push(8'h77);
    rd0 = rd_total; x0 = xfer_total; d0 = done_total;
    ready_mode = 0;
    start(1);
    check_eq("err_cleared", int'(err_o), 0);
    finish_burst("err_next", 1, rd0, x0, d0);

    // Reset after two of five words; buffered and in-flight words are lost
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    x0 = xfer_total;
    ready_mode = 0;
    start(5);
    for (int i = 0; i < 50 && (xfer_total - x0) < 2; i++) tick(1);
    check_eq("rst_two_sent", int'(xfer_total - x0 >= 2), 1);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    check_eq("rst_idle_busy", int'(busy_o), 0);
    check_eq("rst_idle_valid", int'(m_valid_o), 0);
    lost = rd_total - xfer_total - dropped_total;
    for (int i = 0; i < lost && exp_q.size() > 0; i++) void'(exp_q.pop_front());
    dropped_total += lost;
    run_burst("rst_next", 1, 0, 1'b0);

    // Zero-length request is ignored
    rd0 = rd_total; d0 = done_total;
    start(0);
    tick(3);
    check_eq("zero_len_busy", int'(busy_o), 0);
    check_eq("zero_len_reads", rd_total - rd0, 0);
    check_eq("zero_len_done", done_total - d0, 0);

    // Randomized bursts with random backpressure, stalls and ignored mid-burst starts
    // (the leftover words from the aborted burst are consumed first)
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) push(8'($urandom));
      run_burst("rand", len, 2, ($urandom_range(0, 2) == 0));
    end

    ready_mode = 0;
    tick(3);
    check_eq("scoreboard_drained", int'(exp_q.size()) - (wptr - rptr), 0);
    ok = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
